nfu2_seq_ctrl: RTL and testbench



---
 rtl/nfu2_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_nfu2_seq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nfu2_seq_ctrl.sv
// Sequencer for the NFU-2 adder-tree datapath: loads a partial sum per output
// group, streams tiles with per-tile selects from the config RAM, then drains and writes.
module nfu2_seq_ctrl #(
  parameter int L1_SEL_W = 128,
  parameter int L2_SEL_W = 192,
  parameter int CFG_AW   = 8,
  parameter int CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_start,
  input  logic [CNT_W-1:0]             i_num_groups,
  input  logic [CNT_W-1:0]             i_num_tiles,
  input  logic [CFG_AW-1:0]            i_cfg_base,
  output logic                         o_busy,
  output logic                         o_done,
  input  logic                         i_psum_valid,
  output logic                         o_psum_ready,
  output logic                         o_load_partial_sum,
  input  logic                         i_nfu1_valid,
  output logic                         o_nfu1_ready,
  output logic                         o_nfu1_en,
  output logic                         o_cfg_rd,
  output logic [CFG_AW-1:0]            o_cfg_addr,
  input  logic [L1_SEL_W+L2_SEL_W-1:0] i_cfg_data,
  output logic [L1_SEL_W-1:0]          o_l1_sel_lines,
  output logic [L2_SEL_W-1:0]          o_l2_sel_lines,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [CNT_W-1:0]             o_group_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ACCUM, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   num_groups_q;
  logic [CNT_W-1:0]   num_tiles_q;
  logic [CNT_W-1:0]   tile_cnt;
  logic [CFG_AW-1:0]  cfg_ptr;
  logic               drain_cnt;
  logic               sel_vld;

  logic psum_hs, accept, out_hs, last_tile, last_group;

  assign psum_hs    = o_psum_ready & i_psum_valid;
  assign accept     = o_nfu1_ready & i_nfu1_valid;
  assign out_hs     = o_out_valid & i_out_ready;
  assign last_tile  = (tile_cnt + CNT_W'(1)) == num_tiles_q;
  assign last_group = o_group_idx == (num_groups_q - CNT_W'(1));

  // Enables follow the valid inputs directly so a tile is taken in the same cycle.
  assign o_load_partial_sum = psum_hs;
  assign o_nfu1_en          = accept;
  assign o_cfg_rd           = accept;
  assign o_cfg_addr         = o_nfu1_ready ? cfg_ptr : '0;

  // The RAM word arrives one cycle after the read; outside that slot the selects are zero.
  assign o_l1_sel_lines = sel_vld ? i_cfg_data[L1_SEL_W-1:0] : '0;
  assign o_l2_sel_lines = sel_vld ? i_cfg_data[L1_SEL_W+L2_SEL_W-1:L1_SEL_W] : '0;

  // NOTE: every path through an always_comb starts from a default, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = (i_num_groups == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (psum_hs) state_nxt = (num_tiles_q == '0) ? S_DRAIN : S_ACCUM;
      S_ACCUM: if (accept && last_tile) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt) state_nxt = S_WRITE;
      S_WRITE: if (out_hs) state_nxt = last_group ? S_DONE : S_LOAD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_psum_ready <= 1'b0;
      o_nfu1_ready <= 1'b0;
      o_out_valid  <= 1'b0;
      o_group_idx  <= '0;
      num_groups_q <= '0;
      num_tiles_q  <= '0;
      tile_cnt     <= '0;
      cfg_ptr      <= '0;
      drain_cnt    <= 1'b0;
      sel_vld      <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_busy       <= state_nxt != S_IDLE;
      o_psum_ready <= state_nxt == S_LOAD;
      o_nfu1_ready <= state_nxt == S_ACCUM;
      o_out_valid  <= state_nxt == S_WRITE;
      o_done       <= state == S_DONE;
      sel_vld      <= o_cfg_rd;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            num_groups_q <= i_num_groups;
            num_tiles_q  <= i_num_tiles;
            cfg_ptr      <= i_cfg_base;
            o_group_idx  <= '0;
          end
        end
        S_LOAD: begin
          tile_cnt  <= '0;
          drain_cnt <= 1'b0;
        end
        S_ACCUM: begin
          // The pointer is never rewound, so groups read consecutive config words.
          if (accept) begin
            cfg_ptr  <= cfg_ptr + CFG_AW'(1);
            tile_cnt <= tile_cnt + CNT_W'(1);
          end
        end
        S_DRAIN: drain_cnt <= 1'b1;
        S_WRITE: begin
          if (out_hs && !last_group) o_group_idx <= o_group_idx + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nfu2_seq_ctrl.sv
// Directed bench for nfu2_seq_ctrl with a small config-RAM and accumulator
// model standing in for the NFU-2 datapath.
module tb_nfu2_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start;
  logic [7:0]   i_num_groups, i_num_tiles, i_cfg_base;
  logic         o_busy, o_done;
  logic         i_psum_valid, o_psum_ready, o_load_partial_sum;
  logic         i_nfu1_valid, o_nfu1_ready, o_nfu1_en;
  logic         o_cfg_rd;
  logic [7:0]   o_cfg_addr;
  logic [319:0] i_cfg_data = {10{32'hDEADBEEF}};
  logic [127:0] o_l1_sel_lines;
  logic [191:0] o_l2_sel_lines;
  logic         o_out_valid, i_out_ready;
  logic [7:0]   o_group_idx;

  int errors = 0;
  int checks = 0;

  logic [15:0] psum_in  = '0;
  logic [15:0] tile_val = '0;
  logic [15:0] nfu1_q   = '0;
  logic [15:0] sum_q    = '0;

  nfu2_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_num_groups(i_num_groups), .i_num_tiles(i_num_tiles), .i_cfg_base(i_cfg_base),
    .o_busy(o_busy), .o_done(o_done),
    .i_psum_valid(i_psum_valid), .o_psum_ready(o_psum_ready),
    .o_load_partial_sum(o_load_partial_sum),
    .i_nfu1_valid(i_nfu1_valid), .o_nfu1_ready(o_nfu1_ready), .o_nfu1_en(o_nfu1_en),
    .o_cfg_rd(o_cfg_rd), .o_cfg_addr(o_cfg_addr), .i_cfg_data(i_cfg_data),
    .o_l1_sel_lines(o_l1_sel_lines), .o_l2_sel_lines(o_l2_sel_lines),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_group_idx(o_group_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] l1w(input logic [7:0] a);
    return {16{a ^ 8'hA5}};
  endfunction

  function automatic logic [191:0] l2w(input logic [7:0] a);
    return {24{a}};
  endfunction

  // Config RAM with one-cycle read latency; output holds when not read.
  always @(posedge clk) if (o_cfg_rd) i_cfg_data <= {l2w(o_cfg_addr), l1w(o_cfg_addr)};

  // Datapath stand-in: tile register then accumulate; the load overwrites the sum.
  always @(posedge clk) begin
    nfu1_q <= o_nfu1_en ? tile_val : 16'd0;
    sum_q  <= o_load_partial_sum ? psum_in : sum_q + nfu1_q;
  end

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input logic [7:0] g, input logic [7:0] t, input logic [7:0] b);
    i_start = 1'b1; i_num_groups = g; i_num_tiles = t; i_cfg_base = b;
  endtask

  // One group with nfu1_valid toggling 1-0-1-0-1 and out_ready held low for 4 cycles.
  task automatic stall_group(input logic [7:0] a0, input logic [7:0] gidx,
                             input logic [15:0] exp_sum, input logic [15:0] next_psum);
    i_out_ready = 1'b0;
    #1;
    check("stall_load_ready", o_psum_ready, 1'b1);
    check("stall_group_idx", o_group_idx, gidx);
    step();
    for (int ph = 0; ph < 5; ph++) begin
      i_nfu1_valid = (ph % 2) == 0;
      #1;
      check("stall_en_follows_valid", o_nfu1_en, i_nfu1_valid);
      if (i_nfu1_valid) check("stall_addr", o_cfg_addr, a0 + 8'(ph / 2));
      step();
    end
    i_nfu1_valid = 1'b0;
    repeat (2) begin
      #1;
      check("stall_drain_no_valid", o_out_valid, 1'b0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_out_valid_hold", o_out_valid, 1'b1);
      check("stall_sum", sum_q, exp_sum);
      step();
    end
    i_out_ready = 1'b1;
    psum_in = next_psum;
    #1;
    check("stall_out_valid_hs", o_out_valid, 1'b1);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with random inputs for three edges.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_start = 1'($urandom); i_num_groups = 8'($urandom); i_num_tiles = 8'($urandom);
      i_cfg_base = 8'($urandom); i_psum_valid = 1'($urandom);
      i_nfu1_valid = 1'($urandom); i_out_ready = 1'($urandom);
      step();
    end
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_psum_ready", o_psum_ready, 1'b0);
    check("rst_load", o_load_partial_sum, 1'b0);
    check("rst_nfu1_ready", o_nfu1_ready, 1'b0);
    check("rst_nfu1_en", o_nfu1_en, 1'b0);
    check("rst_cfg_rd", o_cfg_rd, 1'b0);
    check("rst_cfg_addr", o_cfg_addr, 8'h00);
    check("rst_l1", o_l1_sel_lines, '0);
    check("rst_l2", o_l2_sel_lines, '0);
    check("rst_out_valid", o_out_valid, 1'b0);
    check("rst_group_idx", o_group_idx, 8'h00);
    rst_n = 1'b1; i_start = 1'b0; i_num_groups = '0; i_num_tiles = '0; i_cfg_base = '0;
    i_psum_valid = 1'b0; i_nfu1_valid = 1'b0; i_out_ready = 1'b0;

    // Single group, 4 tiles, no stalls: done at cycle 10.
    set_job(8'd1, 8'd4, 8'h10);
    psum_in = 16'd5; tile_val = 16'd16;
    i_psum_valid = 1'b1; i_nfu1_valid = 1'b1; i_out_ready = 1'b1;
    #1;
    check("c0_busy", o_busy, 1'b0);
    step();
    i_start = 1'b0; i_num_groups = 8'd0; i_num_tiles = 8'd9;
    #1;
    check("c1_busy", o_busy, 1'b1);
    check("c1_psum_ready", o_psum_ready, 1'b1);
    check("c1_load", o_load_partial_sum, 1'b1);
    check("c1_nfu1_en", o_nfu1_en, 1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      #1;
      check("seq_addr", o_cfg_addr, 8'h10 + 8'(k));
      check("seq_cfg_rd", o_cfg_rd, 1'b1);
      check("seq_load_low", o_load_partial_sum, 1'b0);
      if (k > 0) begin
        check("seq_l1", o_l1_sel_lines, l1w(8'h10 + 8'(k - 1)));
        check("seq_l2", o_l2_sel_lines, l2w(8'h10 + 8'(k - 1)));
      end
      step();
    end
    #1;
    check("c6_en_drain", o_nfu1_en, 1'b0);
    check("c6_l1", o_l1_sel_lines, l1w(8'h13));
    check("c6_l2", o_l2_sel_lines, l2w(8'h13));
    step();
    check("c7_l1_zero", o_l1_sel_lines, '0);
    check("c7_out_valid", o_out_valid, 1'b0);
    step();
    check("c8_out_valid", o_out_valid, 1'b1);
    check("c8_sum", sum_q, 16'd69);
    step();
    check("c9_out_valid", o_out_valid, 1'b0);
    check("c9_done", o_done, 1'b0);
    step();
    check("c10_done", o_done, 1'b1);
    check("c10_busy", o_busy, 1'b0);
    step();
    check("c11_done", o_done, 1'b0);

    // Two groups of 3 tiles with stalls; pointer continues across groups.
    set_job(8'd2, 8'd3, 8'h40);
    psum_in = 16'd7; tile_val = 16'd3; i_nfu1_valid = 1'b0;
    step();
    i_start = 1'b0;
    stall_group(8'h40, 8'd0, 16'd16, 16'd20);
    stall_group(8'h43, 8'd1, 16'd29, 16'd0);
    check("stall_done_state_busy", o_busy, 1'b1);
    step();
    check("stall_done", o_done, 1'b1);

    // Address wrap: FE, FF, 00, 01.
    set_job(8'd2, 8'd2, 8'hFE);
    psum_in = 16'd0; tile_val = 16'd1;
    i_psum_valid = 1'b1; i_nfu1_valid = 1'b1; i_out_ready = 1'b1;
    step();
    i_start = 1'b0;
    step();
    check("wrap_a0", o_cfg_addr, 8'hFE);
    step();
    check("wrap_a1", o_cfg_addr, 8'hFF);
    repeat (3) step();
    check("wrap_write0", o_out_valid, 1'b1);
    check("wrap_gidx0", o_group_idx, 8'd0);
    step();
    check("wrap_gidx1", o_group_idx, 8'd1);
    step();
    check("wrap_a2", o_cfg_addr, 8'h00);
    step();
    check("wrap_a3", o_cfg_addr, 8'h01);
    repeat (3) step();
    check("wrap_write1", o_out_valid, 1'b1);
    repeat (2) step();
    check("wrap_done", o_done, 1'b1);

    // Zero tiles: the loaded psum passes straight through.
    set_job(8'd1, 8'd0, 8'h80);
    psum_in = 16'd42;
    step();
    i_start = 1'b0;
    check("t0_load", o_load_partial_sum, 1'b1);
    step();
    check("t0_cfg_rd_d0", o_cfg_rd, 1'b0);
    step();
    check("t0_cfg_rd_d1", o_cfg_rd, 1'b0);
    step();
    check("t0_cfg_rd_w", o_cfg_rd, 1'b0);
    check("t0_out_valid", o_out_valid, 1'b1);
    check("t0_sum", sum_q, 16'd42);
    repeat (2) step();
    check("t0_done", o_done, 1'b1);

    // Zero groups: done two cycles after start, no handshakes.
    set_job(8'd0, 8'd3, 8'h00);
    step();
    i_start = 1'b0;
    check("g0_busy", o_busy, 1'b1);
    check("g0_psum_ready", o_psum_ready, 1'b0);
    check("g0_nfu1_en", o_nfu1_en, 1'b0);
    step();
    check("g0_done", o_done, 1'b1);
    check("g0_out_valid", o_out_valid, 1'b0);
    step();

    // Reset during ACCUM, then a fresh job with a start pulse during WRITE.
    set_job(8'd1, 8'd4, 8'h20);
    step();
    i_start = 1'b0;
    step();
    check("mr_accum_rd", o_cfg_rd, 1'b1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mr_busy", o_busy, 1'b0);
    check("mr_nfu1_en", o_nfu1_en, 1'b0);
    check("mr_cfg_rd", o_cfg_rd, 1'b0);
    check("mr_psum_ready", o_psum_ready, 1'b0);
    check("mr_l1", o_l1_sel_lines, '0);
    set_job(8'd1, 8'd2, 8'h30);
    psum_in = 16'd1; tile_val = 16'd16;
    step();
    i_start = 1'b0;
    step();
    check("nj_a0", o_cfg_addr, 8'h30);
    step();
    check("nj_a1", o_cfg_addr, 8'h31);
    repeat (3) step();
    i_out_ready = 1'b0; i_start = 1'b1;
    #1;
    check("nj_out_valid", o_out_valid, 1'b1);
    check("nj_sum", sum_q, 16'd33);
    step();
    i_start = 1'b0; i_out_ready = 1'b1;
    #1;
    check("nj_start_ignored_valid", o_out_valid, 1'b1);
    check("nj_start_ignored_ready", o_psum_ready, 1'b0);
    check("nj_gidx", o_group_idx, 8'd0);
    step();
    check("nj_done_state", o_done, 1'b0);
    step();
    check("nj_done", o_done, 1'b1);
    step();
    check("nj_idle_busy", o_busy, 1'b0);
    check("nj_idle_ready", o_psum_ready, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
